// File: rtl/synth_pkg.sv
// Shared types and widths for the synthesizer voice allocation path.
package synth_pkg;

  localparam int KEY_W = 7;
  localparam int VEL_W = 7;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    ISSUE
  } alloc_state_t;

  // Numeric order is the note-on preference order; NONE sorts last.
  typedef enum logic [2:0] {
    RETRIG,
    FREE,
    REL,
    STEAL,
    NONE
  } cand_class_t;

endpackage

// File: rtl/voice_lru_table.sv
// Least-recently-allocated age table: a permutation of 0..VOICES-1 where the
// largest age marks the voice allocated longest ago.
module voice_lru_table #(
  parameter int VOICES  = 32,
  parameter int V_WIDTH = $clog2(VOICES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [V_WIDTH-1:0] i_rd_idx,
  output logic [V_WIDTH-1:0] o_rd_age,
  input  logic               i_alloc,
  input  logic [V_WIDTH-1:0] i_alloc_idx
);

  logic [V_WIDTH-1:0] r_age [VOICES];
  logic [V_WIDTH-1:0] w_alloc_age;

  assign o_rd_age    = r_age[i_rd_idx];
  assign w_alloc_age = r_age[i_alloc_idx];

  // Younger voices age by one and the allocated voice becomes the youngest,
  // so the table stays a permutation after every allocation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < VOICES; i++) begin
        r_age[i] <= V_WIDTH'(VOICES - 1 - i);
      end
    end else if (i_alloc) begin
      for (int i = 0; i < VOICES; i++) begin
        if (V_WIDTH'(i) == i_alloc_idx) begin
          r_age[i] <= '0;
        end else if (r_age[i] < w_alloc_age) begin
          r_age[i] <= r_age[i] + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Assigns MIDI note events to synth voices, scanning one voice per cycle and
// stealing released voices before gated ones when nothing is idle.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int VOICES  = 32,
  parameter int V_WIDTH = $clog2(VOICES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               note_req,
  input  logic               note_is_on,
  input  logic [KEY_W-1:0]   note_key,
  input  logic [VEL_W-1:0]   note_vel,
  output logic               req_ready,
  input  logic [VOICES-1:0]  voice_free,
  output logic [VOICES-1:0]  keys_on,
  output logic               note_on,
  output logic               note_off,
  output logic [V_WIDTH-1:0] cur_key_adr,
  output logic [7:0]         cur_key_val,
  output logic [7:0]         cur_vel_on,
  output logic [7:0]         cur_vel_off,
  output logic [V_WIDTH:0]   active_keys,
  output logic               steal,
  output logic               off_note_error
);

  localparam int CNT_W = V_WIDTH + 1;
  localparam logic [V_WIDTH-1:0] LAST_IDX = V_WIDTH'(VOICES - 1);

  alloc_state_t       r_state;
  logic [V_WIDTH-1:0] r_idx;
  logic               r_is_on;
  logic [KEY_W-1:0]   r_key;
  logic [VEL_W-1:0]   r_vel;
  cand_class_t        r_best_class;
  logic [V_WIDTH-1:0] r_best_idx;
  logic [V_WIDTH-1:0] r_best_age;

  logic [VOICES-1:0]  r_keys_on;
  logic [KEY_W-1:0]   r_key_mem [VOICES];
  logic               r_req_ready;
  logic               r_note_on;
  logic               r_note_off;
  logic               r_steal;
  logic               r_off_err;
  logic [V_WIDTH-1:0] r_cur_key_adr;
  logic [7:0]         r_cur_key_val;
  logic [7:0]         r_cur_vel_on;
  logic [7:0]         r_cur_vel_off;
  logic [CNT_W-1:0]   r_active_keys;

  logic [V_WIDTH-1:0] w_age;
  cand_class_t        w_class;
  logic               w_take;
  logic               w_gated;
  logic               w_key_match;
  logic               w_alloc;
  logic [VOICES-1:0]  w_keys_next;
  logic [CNT_W-1:0]   w_count;

  assign w_alloc = (r_state == ISSUE) && r_is_on && (r_best_class != NONE);

  voice_lru_table #(
    .VOICES (VOICES),
    .V_WIDTH(V_WIDTH)
  ) u_lru (
    .clk        (clk),
    .reset      (reset),
    .i_rd_idx   (r_idx),
    .o_rd_age   (w_age),
    .i_alloc    (w_alloc),
    .i_alloc_idx(r_best_idx)
  );

  // Classify the voice under the scan pointer and decide whether it beats
  // the best candidate so far; a note-off only ever keeps the first match.
  always_comb begin
    w_gated     = r_keys_on[r_idx];
    w_key_match = (r_key_mem[r_idx] == r_key);
    w_class     = NONE;
    if (r_is_on) begin
      if (w_gated && w_key_match)         w_class = RETRIG;
      else if (!w_gated && voice_free[r_idx]) w_class = FREE;
      else if (!w_gated)                  w_class = REL;
      else                                w_class = STEAL;
    end else if (w_gated && w_key_match) begin
      w_class = RETRIG;
    end
    w_take = 1'b0;
    if (w_class != NONE) begin
      if (r_is_on) begin
        w_take = (w_class < r_best_class) ||
                 ((w_class == r_best_class) && (w_age > r_best_age));
      end else begin
        w_take = (r_best_class == NONE);
      end
    end
  end

  always_comb begin
    w_keys_next = r_keys_on;
    if (r_best_class != NONE) begin
      w_keys_next[r_best_idx] = r_is_on;
    end
    w_count = '0;
    for (int i = 0; i < VOICES; i++) begin
      w_count = w_count + CNT_W'(w_keys_next[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_is_on       <= 1'b0;
      r_key         <= '0;
      r_vel         <= '0;
      r_best_class  <= NONE;
      r_best_idx    <= '0;
      r_best_age    <= '0;
      r_keys_on     <= '0;
      for (int i = 0; i < VOICES; i++) begin
        r_key_mem[i] <= '0;
      end
      r_req_ready   <= 1'b1;
      r_note_on     <= 1'b0;
      r_note_off    <= 1'b0;
      r_steal       <= 1'b0;
      r_off_err     <= 1'b0;
      r_cur_key_adr <= '0;
      r_cur_key_val <= '0;
      r_cur_vel_on  <= '0;
      r_cur_vel_off <= '0;
      r_active_keys <= '0;
    end else begin
      r_note_on  <= 1'b0;
      r_note_off <= 1'b0;
      r_steal    <= 1'b0;
      r_off_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (note_req) begin
            // A note-on with zero velocity is a note-off by MIDI convention.
            r_is_on      <= note_is_on && (note_vel != '0);
            r_key        <= note_key;
            r_vel        <= note_vel;
            r_idx        <= '0;
            r_best_class <= NONE;
            r_best_idx   <= '0;
            r_best_age   <= '0;
            r_req_ready  <= 1'b0;
            r_state      <= SCAN;
          end
        end
        SCAN: begin
          if (w_take) begin
            r_best_class <= w_class;
            r_best_idx   <= r_idx;
            r_best_age   <= w_age;
          end
          if (r_idx == LAST_IDX) begin
            r_state <= ISSUE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ISSUE: begin
          if (r_best_class == NONE) begin
            r_off_err <= 1'b1;
          end else begin
            r_keys_on     <= w_keys_next;
            r_active_keys <= w_count;
            r_cur_key_adr <= r_best_idx;
            r_cur_key_val <= {1'b0, r_key};
            if (r_is_on) begin
              r_key_mem[r_best_idx] <= r_key;
              r_cur_vel_on          <= {1'b0, r_vel};
              r_note_on             <= 1'b1;
              r_steal               <= (r_best_class == STEAL);
            end else begin
              r_cur_vel_off <= {1'b0, r_vel};
              r_note_off    <= 1'b1;
            end
          end
          r_req_ready <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready      = r_req_ready;
  assign keys_on        = r_keys_on;
  assign note_on        = r_note_on;
  assign note_off       = r_note_off;
  assign steal          = r_steal;
  assign off_note_error = r_off_err;
  assign cur_key_adr    = r_cur_key_adr;
  assign cur_key_val    = r_cur_key_val;
  assign cur_vel_on     = r_cur_vel_on;
  assign cur_vel_off    = r_cur_vel_off;
  assign active_keys    = r_active_keys;

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed scenarios plus randomized events checked
// against a timestamp-based LRU reference model.
module tb_voice_allocator;

  localparam int VOICES = 32;
  localparam int VW     = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          note_req;
  logic          note_is_on;
  logic [6:0]    note_key;
  logic [6:0]    note_vel;
  logic          req_ready;
  logic [31:0]   voice_free;
  logic [31:0]   keys_on;
  logic          note_on;
  logic          note_off;
  logic [VW-1:0] cur_key_adr;
  logic [7:0]    cur_key_val;
  logic [7:0]    cur_vel_on;
  logic [7:0]    cur_vel_off;
  logic [VW:0]   active_keys;
  logic          steal;
  logic          off_note_error;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: gate, stored key and last-allocation timestamp per voice.
  bit            m_gated [VOICES];
  logic [6:0]    m_key   [VOICES];
  int            m_stamp [VOICES];
  int            m_time;
  logic [VW-1:0] exp_adr;
  logic [7:0]    exp_kval, exp_von, exp_voff;
  bit            exp_on, exp_off, exp_steal, exp_err;

  voice_allocator #(.VOICES(VOICES)) dut (
    .clk           (clk),
    .reset         (reset),
    .note_req      (note_req),
    .note_is_on    (note_is_on),
    .note_key      (note_key),
    .note_vel      (note_vel),
    .req_ready     (req_ready),
    .voice_free    (voice_free),
    .keys_on       (keys_on),
    .note_on       (note_on),
    .note_off      (note_off),
    .cur_key_adr   (cur_key_adr),
    .cur_key_val   (cur_key_val),
    .cur_vel_on    (cur_vel_on),
    .cur_vel_off   (cur_vel_off),
    .active_keys   (active_keys),
    .steal         (steal),
    .off_note_error(off_note_error)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < VOICES; i++) v[i] = m_gated[i];
    return v;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < VOICES; i++) c += int'(m_gated[i]);
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < VOICES; i++) begin
      m_gated[i] = 1'b0;
      m_key[i]   = '0;
      m_stamp[i] = i - VOICES;
    end
    m_time   = 0;
    exp_adr  = '0;
    exp_kval = '0;
    exp_von  = '0;
    exp_voff = '0;
    {exp_on, exp_off, exp_steal, exp_err} = '0;
  endtask

  // Oldest voice = smallest allocation timestamp; lower class rank wins first.
  task automatic model_event(input bit on, input logic [6:0] key, input logic [6:0] vel,
                             input logic [31:0] free);
    int pick = -1;
    int bcls = 9;
    int cls;
    {exp_on, exp_off, exp_steal, exp_err} = '0;
    if (on && vel != 0) begin
      for (int i = 0; i < VOICES; i++) begin
        if (m_gated[i] && m_key[i] == key) cls = 0;
        else if (!m_gated[i] && free[i])   cls = 1;
        else if (!m_gated[i])              cls = 2;
        else                               cls = 3;
        if (pick < 0 || cls < bcls || (cls == bcls && m_stamp[i] < m_stamp[pick])) begin
          pick = i;
          bcls = cls;
        end
      end
      m_gated[pick] = 1'b1;
      m_key[pick]   = key;
      m_time++;
      m_stamp[pick] = m_time;
      exp_on    = 1'b1;
      exp_steal = (bcls == 3);
      exp_adr   = VW'(pick);
      exp_kval  = {1'b0, key};
      exp_von   = {1'b0, vel};
    end else begin
      for (int i = 0; i < VOICES; i++) begin
        if (pick < 0 && m_gated[i] && m_key[i] == key) pick = i;
      end
      if (pick < 0) begin
        exp_err = 1'b1;
      end else begin
        m_gated[pick] = 1'b0;
        exp_off  = 1'b1;
        exp_adr  = VW'(pick);
        exp_kval = {1'b0, key};
        exp_voff = {1'b0, vel};
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Issues one event and leaves time at 1 unit after the result edge; also
  // reports what the DUT showed one cycle before the result was due.
  task automatic applyStimulus(input bit on, input logic [6:0] key, input logic [6:0] vel,
                               input logic [31:0] free, output logic early_ready,
                               output logic early_pulse);
    @(negedge clk);
    note_req   = 1'b1;
    note_is_on = on;
    note_key   = key;
    note_vel   = vel;
    voice_free = free;
    @(posedge clk);
    #1;
    note_req   = 1'b0;
    note_is_on = 1'($urandom);
    note_key   = 7'($urandom);
    note_vel   = 7'($urandom);
    repeat (VOICES) @(posedge clk);
    #1;
    early_ready = req_ready;
    early_pulse = note_on | note_off | steal | off_note_error;
    @(posedge clk);
    #1;
    model_event(on, key, vel, free);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      $display("[TB] FAIL reset_ready: got %b want 1", req_ready);
      miscompares++;
    end
    vectors++;
    if ({keys_on, note_on, note_off, steal, off_note_error} !== '0) begin
      $display("[TB] FAIL reset_gates: got keys %h pulses %b%b%b%b want 0", keys_on,
               note_on, note_off, steal, off_note_error);
      miscompares++;
    end
    vectors++;
    if ({cur_key_adr, cur_key_val, cur_vel_on, cur_vel_off, active_keys} !== '0) begin
      $display("[TB] FAIL reset_cur: got adr %0d key %0d von %0d voff %0d act %0d want 0",
               cur_key_adr, cur_key_val, cur_vel_on, cur_vel_off, active_keys);
      miscompares++;
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_first_note();
    logic er, ep;
    applyStimulus(1'b1, 7'd60, 7'd100, 32'h0, er, ep);
    vectors++;
    if (er !== 1'b0 || ep !== 1'b0) begin
      $display("[TB] FAIL first_latency: got ready %b pulse %b one cycle early want 0 0", er, ep);
      miscompares++;
    end
    vectors++;
    if (keys_on !== 32'h1 || cur_key_adr !== 5'd0 || cur_key_val !== 8'd60) begin
      $display("[TB] FAIL first_alloc: got keys %h adr %0d key %0d want 1 0 60",
               keys_on, cur_key_adr, cur_key_val);
      miscompares++;
    end
    vectors++;
    if (cur_vel_on !== 8'd100 || note_on !== 1'b1 || active_keys !== 6'd1 || req_ready !== 1'b1) begin
      $display("[TB] FAIL first_flags: got von %0d on %b act %0d rdy %b want 100 1 1 1",
               cur_vel_on, note_on, active_keys, req_ready);
      miscompares++;
    end
    @(posedge clk);
    #1;
    vectors++;
    if (note_on !== 1'b0) begin
      $display("[TB] FAIL first_pulse_width: got note_on %b want 0", note_on);
      miscompares++;
    end
  endtask

  task automatic test_retrigger();
    logic er, ep;
    applyStimulus(1'b1, 7'd60, 7'd80, 32'hFFFF_FFFE, er, ep);
    vectors++;
    if (cur_key_adr !== 5'd0 || steal !== 1'b0 || note_on !== 1'b1) begin
      $display("[TB] FAIL retrig_voice: got adr %0d steal %b on %b want 0 0 1",
               cur_key_adr, steal, note_on);
      miscompares++;
    end
    vectors++;
    if (active_keys !== 6'd1 || keys_on !== 32'h1 || cur_vel_on !== 8'd80) begin
      $display("[TB] FAIL retrig_state: got act %0d keys %h von %0d want 1 1 80",
               active_keys, keys_on, cur_vel_on);
      miscompares++;
    end
  endtask

  task automatic test_fill_and_steal();
    logic er, ep;
    do_reset();
    for (int i = 0; i < VOICES; i++) begin
      applyStimulus(1'b1, 7'(40 + i), 7'd64, 32'h0, er, ep);
      vectors++;
      if (cur_key_adr !== exp_adr || cur_key_adr !== 5'(i) || steal !== 1'b0) begin
        $display("[TB] FAIL fill_voice_%0d: got adr %0d steal %b want %0d 0",
                 i, cur_key_adr, steal, i);
        miscompares++;
      end
    end
    vectors++;
    if (keys_on !== 32'hFFFF_FFFF || active_keys !== 6'd32) begin
      $display("[TB] FAIL fill_full: got keys %h act %0d want ffffffff 32", keys_on, active_keys);
      miscompares++;
    end
    applyStimulus(1'b1, 7'd90, 7'd127, 32'h0, er, ep);
    vectors++;
    if (cur_key_adr !== 5'd0 || steal !== 1'b1 || note_on !== 1'b1 || cur_key_val !== 8'd90) begin
      $display("[TB] FAIL steal_oldest: got adr %0d steal %b on %b key %0d want 0 1 1 90",
               cur_key_adr, steal, note_on, cur_key_val);
      miscompares++;
    end
    @(posedge clk);
    #1;
    vectors++;
    if (steal !== 1'b0) begin
      $display("[TB] FAIL steal_pulse_width: got %b want 0", steal);
      miscompares++;
    end
  endtask

  // Voice 3 is refreshed so that voice 7 is the older of the two released voices.
  task automatic test_release_class();
    logic er, ep;
    applyStimulus(1'b1, 7'd43, 7'd50, 32'h0, er, ep);
    vectors++;
    if (cur_key_adr !== 5'd3 || steal !== 1'b0) begin
      $display("[TB] FAIL rel_refresh3: got adr %0d steal %b want 3 0", cur_key_adr, steal);
      miscompares++;
    end
    applyStimulus(1'b0, 7'd43, 7'd10, 32'h0, er, ep);
    applyStimulus(1'b0, 7'd47, 7'd11, 32'h0, er, ep);
    vectors++;
    if (keys_on !== 32'hFFFF_FF77 || note_off !== 1'b1 || cur_key_adr !== 5'd7 ||
        cur_vel_off !== 8'd11) begin
      $display("[TB] FAIL rel_offs: got keys %h off %b adr %0d voff %0d want ffffff77 1 7 11",
               keys_on, note_off, cur_key_adr, cur_vel_off);
      miscompares++;
    end
    applyStimulus(1'b1, 7'd100, 7'd70, 32'h0, er, ep);
    vectors++;
    if (cur_key_adr !== 5'd7 || cur_key_adr !== exp_adr || steal !== 1'b0 ||
        active_keys !== 6'd31) begin
      $display("[TB] FAIL rel_class_c: got adr %0d steal %b act %0d want 7 0 31",
               cur_key_adr, steal, active_keys);
      miscompares++;
    end
  endtask

  task automatic test_off_error();
    logic er, ep;
    do_reset();
    applyStimulus(1'b1, 7'd60, 7'd100, 32'h0, er, ep);
    applyStimulus(1'b0, 7'd61, 7'd33, 32'h0, er, ep);
    vectors++;
    if (off_note_error !== 1'b1 || note_off !== 1'b0 || keys_on !== 32'h1) begin
      $display("[TB] FAIL off_nomatch: got err %b off %b keys %h want 1 0 1",
               off_note_error, note_off, keys_on);
      miscompares++;
    end
    vectors++;
    if (cur_key_val !== 8'd60 || cur_vel_off !== 8'd0 || cur_key_adr !== 5'd0) begin
      $display("[TB] FAIL off_nomatch_hold: got key %0d voff %0d adr %0d want 60 0 0",
               cur_key_val, cur_vel_off, cur_key_adr);
      miscompares++;
    end
    @(posedge clk);
    #1;
    vectors++;
    if (off_note_error !== 1'b0) begin
      $display("[TB] FAIL off_err_width: got %b want 0", off_note_error);
      miscompares++;
    end
    applyStimulus(1'b1, 7'd60, 7'd0, 32'h0, er, ep);
    vectors++;
    if (note_off !== 1'b1 || note_on !== 1'b0 || keys_on !== 32'h0 || active_keys !== 6'd0) begin
      $display("[TB] FAIL vel0_off: got off %b on %b keys %h act %0d want 1 0 0 0",
               note_off, note_on, keys_on, active_keys);
      miscompares++;
    end
    vectors++;
    if (cur_vel_on !== 8'd100 || cur_key_adr !== 5'd0) begin
      $display("[TB] FAIL vel0_keeps_von: got von %0d adr %0d want 100 0", cur_vel_on, cur_key_adr);
      miscompares++;
    end
  endtask

  task automatic test_reset_midscan();
    logic er, ep;
    bit   saw_pulse = 1'b0;
    do_reset();
    applyStimulus(1'b1, 7'd70, 7'd90, 32'h0, er, ep);
    @(negedge clk);
    note_req   = 1'b1;
    note_is_on = 1'b1;
    note_key   = 7'd71;
    note_vel   = 7'd20;
    @(posedge clk);
    #1;
    note_req = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #2;
    vectors++;
    if (keys_on !== 32'h0 || cur_key_val !== 8'd0 || active_keys !== 6'd0 ||
        note_on !== 1'b0 || req_ready !== 1'b1) begin
      $display("[TB] FAIL midscan_reset: got keys %h key %0d act %0d on %b rdy %b want 0 0 0 0 1",
               keys_on, cur_key_val, active_keys, note_on, req_ready);
      miscompares++;
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < VOICES + 2; c++) begin
      @(posedge clk);
      #1;
      if (note_on | note_off | steal | off_note_error) saw_pulse = 1'b1;
    end
    vectors++;
    if (saw_pulse !== 1'b0) begin
      $display("[TB] FAIL midscan_no_pulse: got pulse %b want 0", saw_pulse);
      miscompares++;
    end
    applyStimulus(1'b1, 7'd72, 7'd55, 32'h0, er, ep);
    vectors++;
    if (note_on !== 1'b1 || cur_key_adr !== exp_adr || keys_on !== m_vec() ||
        cur_key_val !== 8'd72) begin
      $display("[TB] FAIL midscan_recover: got on %b adr %0d keys %h key %0d want 1 %0d %h 72",
               note_on, cur_key_adr, keys_on, cur_key_val, exp_adr, m_vec());
      miscompares++;
    end
  endtask

  task automatic test_random();
    logic        er, ep;
    bit          on;
    logic [6:0]  key, vel;
    logic [31:0] free;
    int          g[$];
    do_reset();
    for (int n = 0; n < 150; n++) begin
      on = ($urandom_range(0, 9) < 7);
      g.delete();
      for (int i = 0; i < VOICES; i++) if (m_gated[i]) g.push_back(i);
      if (g.size() > 0 && $urandom_range(0, 9) < 5) key = m_key[g[$urandom_range(0, g.size() - 1)]];
      else key = 7'($urandom_range(20, 110));
      vel  = ($urandom_range(0, 9) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
      free = $urandom;
      applyStimulus(on, key, vel, free, er, ep);
      vectors++;
      if (er !== 1'b0 || ep !== 1'b0 || req_ready !== 1'b1) begin
        $display("[TB] FAIL rnd_timing_%0d: got early rdy %b pulse %b rdy %b want 0 0 1",
                 n, er, ep, req_ready);
        miscompares++;
      end
      vectors++;
      if (keys_on !== m_vec() || active_keys !== 6'(m_count())) begin
        $display("[TB] FAIL rnd_gates_%0d: got keys %h act %0d want %h %0d",
                 n, keys_on, active_keys, m_vec(), m_count());
        miscompares++;
      end
      vectors++;
      if ({note_on, note_off, steal, off_note_error} !== {exp_on, exp_off, exp_steal, exp_err}) begin
        $display("[TB] FAIL rnd_pulses_%0d: got on/off/steal/err %b%b%b%b want %b%b%b%b", n,
                 note_on, note_off, steal, off_note_error, exp_on, exp_off, exp_steal, exp_err);
        miscompares++;
      end
      vectors++;
      if (cur_key_adr !== exp_adr || cur_key_val !== exp_kval || cur_vel_on !== exp_von ||
          cur_vel_off !== exp_voff) begin
        $display("[TB] FAIL rnd_cur_%0d: got adr %0d key %0d von %0d voff %0d want %0d %0d %0d %0d",
                 n, cur_key_adr, cur_key_val, cur_vel_on, cur_vel_off,
                 exp_adr, exp_kval, exp_von, exp_voff);
        miscompares++;
      end
      @(posedge clk);
      #1;
      vectors++;
      if ({note_on, note_off, steal, off_note_error} !== 4'b0000) begin
        $display("[TB] FAIL rnd_pulse_width_%0d: got %b%b%b%b want 0000",
                 n, note_on, note_off, steal, off_note_error);
        miscompares++;
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    note_req   = 1'b0;
    note_is_on = 1'b0;
    note_key   = '0;
    note_vel   = '0;
    voice_free = '0;
    test_reset();
    test_first_note();
    test_retrigger();
    test_fill_and_steal();
    test_release_class();
    test_off_error();
    test_reset_midscan();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Assigns incoming MIDI note events to synth-engine voices for the synthesizer top level. It sits between the MIDI note decoder and `synth_engine`, and drives the per-voice gate vector and current-key bus that the engine and envelope generators consume. It tracks exact least-recently-allocated order. When no voice is idle it steals one, preferring released voices over gated ones.

## Interface
- `VOICES`, default 32: number of voices, power of two, 2..64.
- `V_WIDTH`, default `utils::clogb2(VOICES)`: voice index width.

Ports:
- `clk` — in, 1: system clock (CLOCK_25 domain).
- `reset` — in, 1: reset, asynchronous, active-high. One clock; reset is asynchronous and active-high.
- `note_req` — in, 1: event strobe, sampled only while `req_ready` = 1.
- `note_is_on` — in, 1: 1 = note-on, 0 = note-off.
- `note_key` — in, 7: MIDI key number.
- `note_vel` — in, 7: MIDI velocity.
- `req_ready` — out, 1: allocator idle and able to accept a request.
- `voice_free` — in, VOICES: from the envelope generators; 1 = voice silent.
- `keys_on` — out, VOICES: per-voice gate.
- `note_on` — out, 1: one-cycle pulse when a voice is gated.
- `note_off` — out, 1: one-cycle pulse when a voice is released.
- `cur_key_adr` — out, V_WIDTH: voice affected by the last event.
- `cur_key_val` — out, 8: key of the last event, zero-extended.
- `cur_vel_on` — out, 8: velocity of the last note-on.
- `cur_vel_off` — out, 8: velocity of the last note-off.
- `active_keys` — out, V_WIDTH+1: popcount of `keys_on`.
- `steal` — out, 1: pulse, coincident with `note_on`, when a gated voice was taken.
- `off_note_error` — out, 1: pulse when a note-off matched no gated voice.

## Operation
- FSM states: IDLE → SCAN → ISSUE → IDLE.
  - IDLE: `req_ready` = 1. When `note_req` = 1, latch key/vel/type and go to SCAN with `idx` = 0.
  - A note-on with vel = 0 is treated as a note-off.
- SCAN: visits one voice per cycle, `idx` 0..VOICES-1, sampling `keys_on[idx]`, `voice_free[idx]`, stored key[idx] and age[idx] at that cycle.
- Note-on candidate classes, in priority order:
  - (a) gated voice with the same key: retrigger;
  - (b) `voice_free` & ~gated;
  - (c) ~gated & ~free (releasing);
  - (d) gated: steal.
  - Within a class, the highest age wins; ties go to the lower index (first seen).
- Note-off target: the gated voice whose key matches, lowest index.
- ISSUE (one cycle):
  - note-on: set `keys_on[v]`, store key[v], update `cur_*`, pulse `note_on`; pulse `steal` if class (d).
  - note-off: clear `keys_on[v]`, set `cur_vel_off`, pulse `note_off`.
  - note-off with no match: pulse `off_note_error`; `keys_on` and the age table are unchanged; `cur_*` hold.
- LRU age table, holding a permutation of 0..VOICES-1:
  - reset value: age[i] = VOICES-1-i, so voice 0 is oldest;
  - on note-on to voice v: every age < age[v] increments by 1, then age[v] = 0;
  - note-off does not change ages.
- `active_keys` is recomputed at ISSUE.

## Timing
- Reset values: `req_ready` = 1; all other outputs 0; stored keys 0; age as above; FSM in IDLE.
- Request sampled at edge E0. SCAN covers edges E1..E_VOICES.
- At edge E_{VOICES+1}, all outputs update and `req_ready` returns to 1.
  - Latency: VOICES+1 cycles. Throughput: one event per VOICES+1 cycles.
- `note_req` while `req_ready` = 0 is ignored; upstream holds the request.
- `voice_free` may change mid-scan; only the value at that voice's visit cycle counts.
- The `note_on`, `note_off`, `steal` and `off_note_error` pulses are exactly one cycle. `note_on` and `note_off` are never high together.
- `reset` mid-scan aborts the event with no output pulse.

## Structure
- The `synth_pkg` package holds:
  - `alloc_state_t` (IDLE/SCAN/ISSUE);
  - `cand_class_t` (RETRIG/FREE/REL/STEAL/NONE);
  - `KEY_W` = 7.
- Sub-module `voice_lru_table`: age registers, the increment-on-allocate update, and the read port indexed by `idx`.
- The top-level block holds the FSM, candidate tracking and the key/gate registers.

## Test plan
- After reset, note-on key 60 vel 100 → at E33: `keys_on` = 0x1, `cur_key_adr` = 0, `cur_key_val` = 60, `cur_vel_on` = 100, `note_on` pulse, `active_keys` = 1.
- Note-on key 60 again while gated → same voice 0 retriggered, `steal` = 0, `active_keys` stays 1.
- 32 distinct note-ons with all `voice_free` = 0 → `keys_on` = 0xFFFFFFFF. A 33rd note-on key 90 → voice 0 stolen, `steal` pulse, `cur_key_val` = 90.
- Voices 3 and 7 released, voice 7 allocated earlier than voice 3, `voice_free` = 0 → the next note-on takes voice 7 (class c, oldest).
- Note-off key 61 with no gated match → `off_note_error` pulse, `keys_on` unchanged. Note-on vel 0 for a gated key 60 → `note_off` pulse, that voice's gate cleared.
- Assert `reset` at scan cycle 10 → all outputs 0 next cycle, no `note_on`; the next request is served normally.
